// File: rtl/fft_butterfly_r2_pipe.sv
// Radix-2 DIT butterfly, three register stages: Yp = Xp + W*Xq, Yq = Xp - W*Xq.
// Per-sample conj(W) for IFFT, optional divide-by-2, round-half-up, saturation.
module fft_butterfly_r2_pipe #(
  parameter int DW      = 24,
  parameter int TW      = 16,
  parameter int TW_FRAC = 13
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 inverse,
  input  logic                 scale,
  input  logic signed [DW-1:0] xp_real,
  input  logic signed [DW-1:0] xp_imag,
  input  logic signed [DW-1:0] xq_real,
  input  logic signed [DW-1:0] xq_imag,
  input  logic signed [TW-1:0] w_real,
  input  logic signed [TW-1:0] w_imag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] yp_real,
  output logic signed [DW-1:0] yp_imag,
  output logic signed [DW-1:0] yq_real,
  output logic signed [DW-1:0] yq_imag,
  output logic                 out_ovf,
  output logic                 ovf_sticky,
  input  logic                 ovf_clr
);

  localparam int PW = DW + TW;
  localparam int IW = DW + TW + 2;
  localparam logic signed [IW-1:0] SAT_MAX = {{(IW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [IW-1:0] SAT_MIN = {{(IW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [IW-1:0] sext_prod(input logic signed [PW-1:0] v);
    return {{(IW-PW){v[PW-1]}}, v};
  endfunction

  // Round half toward +inf, then arithmetic shift by TW_FRAC (+1 when scaling).
  function automatic logic signed [IW-1:0] round_shift(input logic signed [IW-1:0] v,
                                                       input logic scl);
    logic signed [IW-1:0] half;
    logic signed [IW-1:0] sum;
    half = '0;
    if (scl) half[TW_FRAC] = 1'b1;
    else     half[TW_FRAC-1] = 1'b1;
    sum = v + half;
    return scl ? (sum >>> (TW_FRAC + 1)) : (sum >>> TW_FRAC);
  endfunction

  function automatic logic signed [DW-1:0] saturate(input logic signed [IW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DW-1:0];
    else                  return v[DW-1:0];
  endfunction

  function automatic logic is_sat(input logic signed [IW-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  logic w_adv;
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  // Stage 1: full twiddle products, Xp aligned to the product binary point
  logic signed [PW-1:0] w_ar, w_bi, w_ai, w_br;
  logic signed [IW-1:0] w_xpr_al, w_xpi_al;
  assign w_ar     = PW'(xq_real) * PW'(w_real);
  assign w_bi     = PW'(xq_imag) * PW'(w_imag);
  assign w_ai     = PW'(xq_real) * PW'(w_imag);
  assign w_br     = PW'(xq_imag) * PW'(w_real);
  assign w_xpr_al = IW'(xp_real) <<< TW_FRAC;
  assign w_xpi_al = IW'(xp_imag) <<< TW_FRAC;

  logic                 r_vld_p0, r_inv_p0, r_scl_p0;
  logic signed [PW-1:0] r_ar_p0, r_bi_p0, r_ai_p0, r_br_p0;
  logic signed [IW-1:0] r_xpr_p0, r_xpi_p0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_p0 <= 1'b0;
      r_inv_p0 <= 1'b0;
      r_scl_p0 <= 1'b0;
      r_ar_p0  <= '0;
      r_bi_p0  <= '0;
      r_ai_p0  <= '0;
      r_br_p0  <= '0;
      r_xpr_p0 <= '0;
      r_xpi_p0 <= '0;
    end else if (w_adv) begin
      r_vld_p0 <= in_valid;
      if (in_valid) begin
        r_inv_p0 <= inverse;
        r_scl_p0 <= scale;
        r_ar_p0  <= w_ar;
        r_bi_p0  <= w_bi;
        r_ai_p0  <= w_ai;
        r_br_p0  <= w_br;
        r_xpr_p0 <= w_xpr_al;
        r_xpi_p0 <= w_xpi_al;
      end
    end
  end

  // Stage 2: combine products; conj(W) is folded into the add/sub signs
  logic signed [IW-1:0] w_qr, w_qi;
  assign w_qr = r_inv_p0 ? (sext_prod(r_ar_p0) + sext_prod(r_bi_p0))
                         : (sext_prod(r_ar_p0) - sext_prod(r_bi_p0));
  assign w_qi = r_inv_p0 ? (sext_prod(r_br_p0) - sext_prod(r_ai_p0))
                         : (sext_prod(r_ai_p0) + sext_prod(r_br_p0));

  logic                 r_vld_p1, r_scl_p1;
  logic signed [IW-1:0] r_qr_p1, r_qi_p1, r_xpr_p1, r_xpi_p1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_p1 <= 1'b0;
      r_scl_p1 <= 1'b0;
      r_qr_p1  <= '0;
      r_qi_p1  <= '0;
      r_xpr_p1 <= '0;
      r_xpi_p1 <= '0;
    end else if (w_adv) begin
      r_vld_p1 <= r_vld_p0;
      if (r_vld_p0) begin
        r_scl_p1 <= r_scl_p0;
        r_qr_p1  <= w_qr;
        r_qi_p1  <= w_qi;
        r_xpr_p1 <= r_xpr_p0;
        r_xpi_p1 <= r_xpi_p0;
      end
    end
  end

  // Stage 3: butterfly sums, rounding, saturation
  logic signed [IW-1:0] w_rpr, w_rpi, w_rqr, w_rqi;
  logic                 w_ovf;
  assign w_rpr = round_shift(r_xpr_p1 + r_qr_p1, r_scl_p1);
  assign w_rpi = round_shift(r_xpi_p1 + r_qi_p1, r_scl_p1);
  assign w_rqr = round_shift(r_xpr_p1 - r_qr_p1, r_scl_p1);
  assign w_rqi = round_shift(r_xpi_p1 - r_qi_p1, r_scl_p1);
  assign w_ovf = is_sat(w_rpr) | is_sat(w_rpi) | is_sat(w_rqr) | is_sat(w_rqi);

  logic                 r_vld_p2, r_ovf_p2, r_sticky;
  logic signed [DW-1:0] r_ypr_p2, r_ypi_p2, r_yqr_p2, r_yqi_p2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_p2 <= 1'b0;
      r_ovf_p2 <= 1'b0;
      r_ypr_p2 <= '0;
      r_ypi_p2 <= '0;
      r_yqr_p2 <= '0;
      r_yqi_p2 <= '0;
    end else if (w_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_ovf_p2 <= w_ovf;
        r_ypr_p2 <= saturate(w_rpr);
        r_ypi_p2 <= saturate(w_rpi);
        r_yqr_p2 <= saturate(w_rqr);
        r_yqi_p2 <= saturate(w_rqi);
      end
    end
  end

  // A saturating sample landing in stage 3 beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                             r_sticky <= 1'b0;
    else if (w_adv && r_vld_p1 && w_ovf)   r_sticky <= 1'b1;
    else if (ovf_clr)                      r_sticky <= 1'b0;
  end

  assign out_valid  = r_vld_p2;
  assign out_ovf    = r_ovf_p2;
  assign ovf_sticky = r_sticky;
  assign yp_real    = r_ypr_p2;
  assign yp_imag    = r_ypi_p2;
  assign yq_real    = r_yqr_p2;
  assign yq_imag    = r_yqi_p2;

endmodule

// File: tb/tb_fft_butterfly_r2_pipe.sv
// Bench for fft_butterfly_r2_pipe: directed vectors with literal expectations plus
// a complex-arithmetic reference model checked on every valid output cycle.
module tb_fft_butterfly_r2_pipe;
  localparam int DW = 24;
  localparam int TW = 16;
  localparam int TW_FRAC = 13;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic inverse = 1'b0, scale = 1'b0;
  logic signed [DW-1:0] xp_real = '0, xp_imag = '0, xq_real = '0, xq_imag = '0;
  logic signed [TW-1:0] w_real = '0, w_imag = '0;
  logic out_valid, out_ready = 1'b1;
  logic signed [DW-1:0] yp_real, yp_imag, yq_real, yq_imag;
  logic out_ovf, ovf_sticky, ovf_clr = 1'b0;

  fft_butterfly_r2_pipe #(.DW(DW), .TW(TW), .TW_FRAC(TW_FRAC)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .inverse(inverse), .scale(scale),
    .xp_real(xp_real), .xp_imag(xp_imag), .xq_real(xq_real), .xq_imag(xq_imag),
    .w_real(w_real), .w_imag(w_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .yp_real(yp_real), .yp_imag(yp_imag), .yq_real(yq_real), .yq_imag(yq_imag),
    .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint ypr, ypi, yqr, yqi;
    bit     ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   n_out = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // floor((s + d/2) / d) for positive d
  function automatic longint round_div(input longint s, input longint d);
    longint t;
    t = s + d / 2;
    if (t >= 0) return t / d;
    return -((-t + d - 1) / d);
  endfunction

  function automatic bit out_of_range(input longint v);
    return (v > (longint'(1) <<< (DW-1)) - 1) || (v < -(longint'(1) <<< (DW-1)));
  endfunction

  function automatic longint clamp(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (DW-1)) - 1;
    lo = -(longint'(1) <<< (DW-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic exp_t model(input longint xpr, input longint xpi, input longint xqr,
                                 input longint xqi, input longint wr, input longint wi,
                                 input bit inv, input bit scl);
    longint qr, qi, one, d, a, b, c, e4;
    exp_t r;
    if (!inv) begin
      qr = xqr * wr - xqi * wi;
      qi = xqr * wi + xqi * wr;
    end else begin
      qr = xqr * wr + xqi * wi;
      qi = xqi * wr - xqr * wi;
    end
    one = longint'(1) <<< TW_FRAC;
    d   = scl ? 2 * one : one;
    a  = round_div(xpr * one + qr, d);
    b  = round_div(xpi * one + qi, d);
    c  = round_div(xpr * one - qr, d);
    e4 = round_div(xpi * one - qi, d);
    r.ovf = out_of_range(a) | out_of_range(b) | out_of_range(c) | out_of_range(e4);
    r.ypr = clamp(a);
    r.ypi = clamp(b);
    r.yqr = clamp(c);
    r.yqi = clamp(e4);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("mon_spurious_valid", 1, 0);
        end else begin
          mon_e = exp_q[0];
          chk("mon_yp_real", yp_real, mon_e.ypr);
          chk("mon_yp_imag", yp_imag, mon_e.ypi);
          chk("mon_yq_real", yq_real, mon_e.yqr);
          chk("mon_yq_imag", yq_imag, mon_e.yqi);
          chk("mon_out_ovf", out_ovf, longint'(mon_e.ovf));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(xp_real, xp_imag, xq_real, xq_imag, w_real, w_imag,
                              inverse, scale));
    end
  end

  task automatic drive(input int a_xpr, input int a_xpi, input int a_xqr, input int a_xqi,
                       input int a_wr, input int a_wi, input bit a_inv, input bit a_scl);
    xp_real = DW'(a_xpr);
    xp_imag = DW'(a_xpi);
    xq_real = DW'(a_xqr);
    xq_imag = DW'(a_xqi);
    w_real  = TW'(a_wr);
    w_imag  = TW'(a_wi);
    inverse = a_inv;
    scale   = a_scl;
  endtask

  // One sample through an idle pipe; returns just after the edge that presents it.
  task automatic send_one(input int a_xpr, input int a_xpi, input int a_xqr, input int a_xqi,
                          input int a_wr, input int a_wi, input bit a_inv, input bit a_scl,
                          input bit a_clr);
    @(posedge clk); #1;
    drive(a_xpr, a_xpi, a_xqr, a_xqi, a_wr, a_wi, a_inv, a_scl);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_e0_out_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_e1_out_valid", out_valid, 0);
    ovf_clr = a_clr;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("lat_e2_out_valid", out_valid, 1);
  endtask

  task automatic chk_y(input string tag, input int pr, input int pi, input int qr, input int qi);
    chk({tag, "_yp_real"}, yp_real, pr);
    chk({tag, "_yp_imag"}, yp_imag, pi);
    chk({tag, "_yq_real"}, yq_real, qr);
    chk({tag, "_yq_imag"}, yq_imag, qi);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, held, n0;
    bit will;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf_sticky", ovf_sticky, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    chk_y("rst", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    send_one(100, 0, 50, 0, 8192, 0, 1'b0, 1'b0, 1'b0);
    chk_y("ident", 150, 0, 50, 0);
    chk("ident_ovf", out_ovf, 0);
    chk("ident_sticky", ovf_sticky, 0);

    send_one(1000, 1000, 10, 20, 0, 8192, 1'b0, 1'b0, 1'b0);
    chk_y("twj_fwd", 980, 1010, 1020, 990);
    send_one(1000, 1000, 10, 20, 0, 8192, 1'b1, 1'b0, 1'b0);
    chk_y("twj_inv", 1020, 990, 980, 1010);

    send_one(101, -101, 0, 0, 8192, 0, 1'b0, 1'b1, 1'b0);
    chk_y("scale_rnd", 51, -50, 51, -50);

    send_one(8388607, -8388608, 8388607, -8388608, 8192, 0, 1'b0, 1'b0, 1'b0);
    chk_y("sat", 8388607, -8388608, 0, 0);
    chk("sat_out_ovf", out_ovf, 1);
    chk("sat_sticky", ovf_sticky, 1);

    send_one(5, 6, 7, 8, 8192, 0, 1'b0, 1'b0, 1'b1);
    chk("clr_nosat_sticky", ovf_sticky, 0);
    chk("clr_nosat_out_ovf", out_ovf, 0);
    send_one(8388607, -8388608, 8388607, -8388608, 8192, 0, 1'b0, 1'b0, 1'b1);
    chk("clr_sat_sticky", ovf_sticky, 1);

    // Backpressure: six samples, stall from the third cycle, release later
    @(posedge clk); #1;
    n0 = n_out;
    acc = 0;
    held = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && acc < 6; cyc++) begin
      if (cyc == 2) out_ready = 1'b0;
      if (cyc == 3) held = yp_real;
      if (cyc == 8) begin
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid_held", out_valid, 1);
        chk("bp_yp_real_stable", yp_real, held);
        out_ready = 1'b1;
      end
      drive(1000 * acc + 7, -500 * acc, 300 * acc - 11, 77 * acc + 1, 5793, -5793,
            acc[0], acc[1]);
      in_valid = 1'b1;
      @(negedge clk);
      will = in_ready;
      @(posedge clk); #1;
      if (will) acc++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 6);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("bp_drain_empty", exp_q.size(), 0);
    chk("bp_out_count", n_out - n0, 6);

    // Reset with two samples in flight
    @(posedge clk); #1;
    drive(123, 456, 7, 8, 8192, 0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(-321, 654, 9, 10, 0, 8192, 1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_ovf", out_ovf, 0);
    chk("mid_rst_sticky", ovf_sticky, 0);
    chk_y("mid_rst", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("post_rst_no_stale", out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_butterfly_r2_pipe.md
Name: fft_butterfly_r2_pipe

Overview:
- Parametrised radix-2 DIT butterfly for the streaming FFT/IFFT core: Yp = Xp + W·Xq, Yq = Xp − W·Xq.
- Generalises the fixed 24/16-bit butterfly. Adds:
  - configurable data and twiddle widths;
  - per-sample inverse mode (conjugated twiddle);
  - per-sample divide-by-2 stage scaling;
  - round-half-up and saturation with overflow flags;
  - valid/ready backpressure.
- Sits between the stage memory/reorder buffer and the twiddle ROM in every FFT stage.

Parameters:
- DW, 24, data width of each real/imag component (signed two's complement).
- TW, 16, twiddle component width (signed).
- TW_FRAC, 13, fractional bits of the twiddle (1.0 = 2^TW_FRAC = 8192).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input this cycle.
- inverse  in  1  per-sample mode: 1 = use conj(W) (IFFT).
- scale  in  1  per-sample mode: 1 = divide both outputs by 2.
- xp_real, xp_imag  in  DW each  Xp.
- xq_real, xq_imag  in  DW each  Xq.
- w_real, w_imag  in  TW each  twiddle W.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- yp_real, yp_imag, yq_real, yq_imag  out  DW each  results.
- out_ovf  out  1  this output sample saturated in any component.
- ovf_sticky  out  1  saturation seen since reset or since the last clear.
- ovf_clr  in  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset (async, rstn=0):
  - All pipeline valids, data registers, out_valid, out_ovf and ovf_sticky go to 0.
  - Outputs read 0.
  - A reset mid-operation discards all in-flight samples.
- Handshake:
  - adv = out_ready | ~out_valid.
  - in_ready = adv (combinational).
  - A sample is accepted on a rising edge with in_valid & in_ready.
  - All three stages shift together when adv = 1 and hold completely when adv = 0.
  - Stage valid bits shift with the data, so bubbles propagate.
  - Outputs hold stable while out_valid & ~out_ready.
- Latency: a sample accepted at edge 0 presents out_valid = 1 after edge 2, i.e. 3 cycles with no stalls. Full throughput is 1 sample/cycle.
- inverse and scale are captured with the sample and travel with it; the mode may change every sample.
- S1 (register):
  - Four full products: ar = xq_real·w_real, bi = xq_imag·w_imag, ai = xq_real·w_imag, br = xq_imag·w_real.
  - Xp sign-extended and shifted left by TW_FRAC.
  - inverse and scale registered alongside.
- S2 (register): products combined.
  - Forward: qr = ar − bi, qi = ai + br.
  - Inverse: qr = ar + bi, qi = br − ai.
  - No twiddle negation is performed, so W = −2^(TW−1) is safe.
- S3 (register):
  - Sums Sp = Xp' + q and Sq = Xp' − q, at internal width DW+TW+2 with no intermediate overflow.
  - sh = TW_FRAC + scale.
  - Round half toward +inf: add 2^(sh−1), then arithmetic right shift by sh.
  - Saturate each component to [−2^(DW−1), 2^(DW−1)−1].
  - out_ovf = OR of the four saturation events.
- ovf_sticky:
  - Set on any edge that loads S3 with a valid saturated sample.
  - Cleared by ovf_clr.
  - Set wins when set and clear occur on the same edge.
- Inputs are ignored when in_valid = 0 or in_ready = 0.

Test Plan:
- Identity twiddle. DW=24, TW=16, TW_FRAC=13; xp=(100,0), xq=(50,0), w=(8192,0), inverse=0, scale=0. Expect yp=(150,0), yq=(50,0), out_valid exactly 3 cycles after acceptance, out_ovf=0.
- Twiddle j, forward and inverse. xp=(1000,1000), xq=(10,20), w=(0,8192).
  - inverse=0: expect yp=(980,1010), yq=(1020,990).
  - Same inputs, inverse=1: expect yp=(1020,990), yq=(980,1010).
- Scaling and rounding. xp=(101,−101), xq=0, w=(8192,0), scale=1. Expect yp=yq=(51,−50), i.e. half rounds toward +inf.
- Saturation. xp=(8388607,−8388608), xq=(8388607,−8388608), w=(8192,0), scale=0. Expect yp=(8388607,−8388608) saturated, yq=(0,0), out_ovf=1, ovf_sticky=1.
  - Then pulse ovf_clr with a non-saturating sample entering S3 on the same edge: expect ovf_sticky=0.
  - Repeat with a saturating sample on that edge: expect ovf_sticky stays 1.
- Backpressure. Stream 6 samples back-to-back with out_ready=0 from cycle 2:
  - Expect in_ready=0 once the first sample reaches the output.
  - Expect outputs stable while stalled.
  - Release out_ready: all 6 samples emerge in order with no loss or duplication.
- Reset mid-stream. Assert rstn=0 with 2 samples in flight. Expect out_valid=0 and outputs 0 immediately, and no stale output after rstn deasserts.
